// File: rtl/uart_wb_master.sv
// UART-driven Wishbone initiator: parses 'W'/'R' commands, runs one pipelined bus cycle
// and streams back a status byte ('K', 'E' or '?') plus read data, MSB first.
module uart_wb_master #(
  parameter int WB_TIMEOUT = 1024,
  parameter int RX_TIMEOUT = 5000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);
  localparam int BW = $clog2(WB_TIMEOUT + 1);
  localparam int RW = $clog2(RX_TIMEOUT + 1);
  localparam logic [BW-1:0] BUS_LAST = BW'(WB_TIMEOUT - 1);
  localparam logic [RW-1:0] RX_LAST  = RW'(RX_TIMEOUT - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_Q = 8'h3F;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP} state_t;
  state_t state, next_state;

  logic          we;
  logic [31:0]   adr;
  logic [31:0]   dat;
  logic [31:0]   rdata;
  logic [1:0]    cnt;
  logic [BW-1:0] bus_timer;
  logic [RW-1:0] rx_timer;
  logic [7:0]    code;
  logic [2:0]    last;
  logic [2:0]    idx;
  logic [7:0]    queue_code;
  logic [2:0]    queue_last;
  logic          in_cycle, bus_done, rx_expired, bus_expired, tx_fire, byte_last;

  assign in_cycle    = (state == BUS_REQ) || (state == BUS_WAIT);
  assign bus_done    = in_cycle && (wb_ack_i || wb_err_i);
  assign rx_expired  = (rx_timer == RX_LAST);
  assign bus_expired = (bus_timer == BUS_LAST);
  assign tx_fire     = (state == RESP) && tx_ready_i;
  assign byte_last   = rx_valid_i && (cnt == 2'd3);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:
        if (rx_valid_i)
          next_state = (rx_byte_i == CMD_W || rx_byte_i == CMD_R) ? ADDR : RESP;
      ADDR:
        if (byte_last) begin
          if (we)                          next_state = DATA;
          else if (rx_byte_i[1:0] != 2'b00) next_state = RESP;
          else                             next_state = BUS_REQ;
        end else if (!rx_valid_i && rx_expired) begin
          next_state = IDLE;
        end
      DATA:
        if (byte_last)                          next_state = (adr[1:0] != 2'b00) ? RESP : BUS_REQ;
        else if (!rx_valid_i && rx_expired)     next_state = IDLE;
      BUS_REQ:
        if (bus_done)         next_state = RESP;
        else if (!wb_stall_i) next_state = BUS_WAIT;
      BUS_WAIT:
        if (bus_done || bus_expired) next_state = RESP;
      RESP:
        if (tx_fire && idx == last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Response chosen in the cycle that enters RESP; err beats ack, anything else is 'E'.
  always_comb begin
    queue_code = RSP_E;
    queue_last = 3'd0;
    if (state == IDLE) begin
      queue_code = RSP_Q;
    end else if (in_cycle && wb_ack_i && !wb_err_i) begin
      queue_code = RSP_K;
      queue_last = we ? 3'd0 : 3'd4;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we        <= 1'b0;
      adr       <= '0;
      dat       <= '0;
      rdata     <= '0;
      cnt       <= '0;
      bus_timer <= '0;
      rx_timer  <= '0;
      code      <= '0;
      last      <= '0;
      idx       <= '0;
    end else begin
      if (state != RESP && next_state == RESP) begin
        code <= queue_code;
        last <= queue_last;
        idx  <= '0;
      end else if (tx_fire) begin
        idx <= idx + 3'd1;
      end
      if (in_cycle && wb_ack_i) rdata <= wb_dat_i;
      case (state)
        IDLE:
          if (rx_valid_i) begin
            we       <= (rx_byte_i == CMD_W);
            cnt      <= '0;
            rx_timer <= '0;
          end
        ADDR: begin
          rx_timer <= rx_valid_i ? '0 : rx_timer + 1'b1;
          if (rx_valid_i) begin
            adr <= {adr[23:0], rx_byte_i};
            cnt <= cnt + 2'd1;
          end
        end
        DATA: begin
          rx_timer <= rx_valid_i ? '0 : rx_timer + 1'b1;
          if (rx_valid_i) begin
            dat <= {dat[23:0], rx_byte_i};
            cnt <= cnt + 2'd1;
          end
        end
        BUS_REQ:  bus_timer <= '0;
        BUS_WAIT: bus_timer <= bus_timer + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_adr_o   = '0;
    wb_dat_o   = '0;
    wb_sel_o   = 4'h0;
    tx_valid_o = 1'b0;
    tx_byte_o  = 8'h00;
    busy_o     = (state != IDLE);
    if (in_cycle) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = (state == BUS_REQ);
      wb_we_o  = we;
      wb_adr_o = adr;
      wb_dat_o = we ? dat : 32'h0;
      wb_sel_o = 4'hF;
    end
    if (state == RESP) begin
      tx_valid_o = 1'b1;
      case (idx)
        3'd1:    tx_byte_o = rdata[31:24];
        3'd2:    tx_byte_o = rdata[23:16];
        3'd3:    tx_byte_o = rdata[15:8];
        3'd4:    tx_byte_o = rdata[7:0];
        default: tx_byte_o = code;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master with short timeouts (WB 16, RX 100 cycles).
module tb_uart_wb_master;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        cyc, stb, we;
  logic [31:0] adr, dat, dat_in;
  logic [3:0]  sel;
  logic        stall, ack, err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_b [5];

  uart_wb_master #(.WB_TIMEOUT(16), .RX_TIMEOUT(100)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rx_byte_i(rx_byte), .rx_valid_i(rx_valid),
    .tx_byte_o(tx_byte), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .busy_o(busy),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_adr_o(adr), .wb_dat_o(dat), .wb_sel_o(sel),
    .wb_stall_i(stall), .wb_ack_i(ack), .wb_err_i(err), .wb_dat_i(dat_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] a);
    send_byte(cmd);
    send_byte(a[31:24]);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic set_exp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3; exp_b[4] = b4;
  endtask

  // Drains the response, optionally toggling tx_ready, and checks each byte in order.
  task automatic collect(input string tag, input int n, input bit toggle);
    int k;
    k = 0;
    for (int c = 0; c < 200 && k < n; c++) begin
      tx_ready = toggle ? c[0] : 1'b1;
      if (tx_valid && tx_ready) begin
        check({tag, "_byte"}, 32'(tx_byte), 32'(exp_b[k]));
        k++;
      end
      step();
    end
    check({tag, "_count"}, 32'(k), 32'(n));
    check({tag, "_txv_end"}, 32'(tx_valid), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    tx_ready = 1'b1;
  endtask

  initial begin
    int n;
    bit seen_tx;
    rst = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    stall = 1'b0; ack = 1'b0; err = 1'b0; dat_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    rst = 1'b0;
    step();

    // Write, ack two cycles after accept
    send_cmd(8'h57, 32'h0000_8010);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h41);
    check("wr_cyc", 32'(cyc), 32'd1);
    check("wr_stb", 32'(stb), 32'd1);
    check("wr_we", 32'(we), 32'd1);
    check("wr_adr", adr, 32'h0000_8010);
    check("wr_dat", dat, 32'h0000_0041);
    check("wr_sel", 32'(sel), 32'hF);
    step();
    check("wr_stb_drop", 32'(stb), 32'd0);
    check("wr_cyc_hold", 32'(cyc), 32'd1);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("wr_cyc_end", 32'(cyc), 32'd0);
    set_exp(8'h4B, 8'h00, 8'h00, 8'h00, 8'h00);
    collect("wr_resp", 1, 1'b0);

    // Read with a dropped rx byte during BUS_WAIT, toggling tx_ready
    send_cmd(8'h52, 32'h0000_8000);
    check("rd_cyc", 32'(cyc), 32'd1);
    check("rd_we", 32'(we), 32'd0);
    check("rd_adr", adr, 32'h0000_8000);
    check("rd_sel", 32'(sel), 32'hF);
    step();
    rx_byte = 8'h57; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("rd_rx_drop_cyc", 32'(cyc), 32'd1);
    dat_in = 32'h1234_5678; ack = 1'b1;
    step();
    ack = 1'b0;
    set_exp(8'h4B, 8'h12, 8'h34, 8'h56, 8'h78);
    collect("rd_resp", 5, 1'b1);

    // Stall three cycles, then accept with ack in the accept cycle
    send_cmd(8'h57, 32'h0000_0020);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    stall = 1'b1;
    send_byte(8'hEF);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (stb) n++;
      check("st_adr_stable", adr, 32'h0000_0020);
      if (c == 3) begin
        stall = 1'b0;
        ack = 1'b1;
      end
      step();
    end
    ack = 1'b0;
    check("st_stb_cycles", 32'(n), 32'd4);
    check("st_cyc_end", 32'(cyc), 32'd0);
    set_exp(8'h4B, 8'h00, 8'h00, 8'h00, 8'h00);
    collect("st_resp", 1, 1'b0);

    // err together with ack
    send_cmd(8'h52, 32'h0000_0004);
    step();
    ack = 1'b1; err = 1'b1;
    step();
    ack = 1'b0; err = 1'b0;
    set_exp(8'h45, 8'h00, 8'h00, 8'h00, 8'h00);
    collect("err_resp", 1, 1'b0);

    // Bus timeout, then a late ack
    tx_ready = 1'b0;
    send_cmd(8'h52, 32'h0000_0008);
    check("to_cyc", 32'(cyc), 32'd1);
    step();
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (!cyc) break;
      if (!stb) n++;
      step();
    end
    check("to_wait_cycles", 32'(n), 32'd16);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("to_late_cyc", 32'(cyc), 32'd0);
    check("to_late_byte", 32'(tx_byte), 32'h45);
    set_exp(8'h45, 8'h00, 8'h00, 8'h00, 8'h00);
    collect("to_resp", 1, 1'b0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("to_idle_cyc", 32'(cyc), 32'd0);
    check("to_idle_busy", 32'(busy), 32'd0);

    // Unaligned read: no bus cycle
    send_cmd(8'h52, 32'h0000_8011);
    check("ua_cyc", 32'(cyc), 32'd0);
    set_exp(8'h45, 8'h00, 8'h00, 8'h00, 8'h00);
    collect("ua_resp", 1, 1'b0);

    // Unknown command byte
    send_byte(8'h00);
    set_exp(8'h3F, 8'h00, 8'h00, 8'h00, 8'h00);
    collect("unk_resp", 1, 1'b0);

    // Inter-byte timeout after a lone 'W'
    send_byte(8'h57);
    n = 0;
    seen_tx = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      if (tx_valid) seen_tx = 1'b1;
      step();
      n++;
    end
    check("rxto_cycles", 32'(n), 32'd100);
    check("rxto_no_tx", 32'(seen_tx), 32'd0);

    // Reset during BUS_WAIT
    send_cmd(8'h52, 32'h0000_000C);
    step();
    check("rbw_pre_cyc", 32'(cyc), 32'd1);
    rst = 1'b1;
    #1;
    check("rbw_cyc", 32'(cyc), 32'd0);
    check("rbw_stb", 32'(stb), 32'd0);
    check("rbw_sel", 32'(sel), 32'd0);
    check("rbw_busy", 32'(busy), 32'd0);
    #2;
    rst = 1'b0;
    step();

    // Reset during RESP
    tx_ready = 1'b0;
    send_byte(8'h00);
    check("rrs_pre_txv", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rrs_txv", 32'(tx_valid), 32'd0);
    check("rrs_byte", 32'(tx_byte), 32'd0);
    check("rrs_busy", 32'(busy), 32'd0);
    #2;
    rst = 1'b0;
    tx_ready = 1'b1;
    step();

    // Read after reset, ack in the accept cycle
    send_cmd(8'h52, 32'h0000_0010);
    check("post_adr", adr, 32'h0000_0010);
    dat_in = 32'hA5A5_0F0F; ack = 1'b1;
    step();
    ack = 1'b0;
    set_exp(8'h4B, 8'hA5, 8'hA5, 8'h0F, 8'h0F);
    collect("post_resp", 5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
